// File: rtl/window3x3_linebuf_pkg.sv
// Shared definitions for the cartoon/edge-detection pixel path.
// Holds the pixel width, the packed 3x3 grid width, the slot index
// constants of the grid and the pixel type, which the Sobel stages reuse.
package cartoon_pkg;

    localparam int PIX_W  = 10;
    localparam int GRID_W = 9 * PIX_W;

    // Slot n of the packed grid lives at bits [PIX_W*n +: PIX_W].
    localparam int SLOT_TL = 8;
    localparam int SLOT_TM = 7;
    localparam int SLOT_TR = 6;
    localparam int SLOT_ML = 5;
    localparam int SLOT_MM = 4;
    localparam int SLOT_MR = 3;
    localparam int SLOT_BL = 2;
    localparam int SLOT_BM = 1;
    localparam int SLOT_BR = 0;

    typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/window3x3_linebuf_if.sv
// Pixel stream in / 3x3 window stream out bundle.
//   iValid, iPixel, iFrameStart : raster pixel stream into the window generator
//   oGrid, oValid, oLast        : packed 3x3 window stream to the Sobel stages
// master = the side that feeds pixels, slave = the window generator.
interface window3x3_linebuf_if;
    import cartoon_pkg::*;

    logic              iValid;
    pixel_t            iPixel;
    logic              iFrameStart;
    logic [GRID_W-1:0] oGrid;
    logic              oValid;
    logic              oLast;

    modport master (
        output iValid, iPixel, iFrameStart,
        input  oGrid, oValid, oLast
    );

    modport slave (
        input  iValid, iPixel, iFrameStart,
        output oGrid, oValid, oLast
    );

endinterface

// File: rtl/window3x3_linebuf_line_buffer_ram.sv
// One line of pixel storage.
//   clock : write clock
//   we    : write enable
//   addr  : shared read/write address (column)
//   wdata : data written at addr on the clock edge
//   rdata : combinational read of addr; returns the value held before
//           a write in the same cycle (read-before-write)
// Contents are not reset.
module line_buffer_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 10,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window3x3_linebuf.sv
// Streaming 3x3 neighbourhood generator.
// Accepts one pixel per iValid cycle in raster order, keeps the two previous
// rows in line buffers and emits a registered packed 3x3 grid for every
// position where the whole window lies inside the frame.
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : slave side of the pixel-in / window-out bundle
module window3x3_linebuf
    import cartoon_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic          clock,
    input  logic          reset,
    window3x3_linebuf_if.slave bus
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col, col_eff, col_nxt;
    logic [ROW_W-1:0] row, row_eff, row_nxt;
    logic             accept, start, win_ok, win_last;
    pixel_t           top, mid;
    pixel_t           win_q [9];
    logic             valid_q, last_q;
    logic [GRID_W-1:0] grid;

    assign accept = bus.iValid;
    assign start  = bus.iValid & bus.iFrameStart;

    // A frame start retags the accepted pixel as (0,0); everything for this
    // pixel (buffer address, validity, next counter) works from that tag.
    always_comb begin
        col_eff = start ? '0 : col;
        row_eff = start ? '0 : row;
        col_nxt = col;
        row_nxt = row;
        if (accept) begin
            if (col_eff == COL_LAST) begin
                col_nxt = '0;
                row_nxt = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
            end else begin
                col_nxt = col_eff + 1'b1;
                row_nxt = row_eff;
            end
        end
    end

    // Columns 0/1 would mix the end of the previous line into the window,
    // rows 0/1 would see stale buffer contents; both are masked here.
    assign win_ok   = accept && (row_eff >= ROW_W'(2)) && (col_eff >= COL_W'(2));
    assign win_last = win_ok && (row_eff == ROW_LAST) && (col_eff == COL_LAST);

    line_buffer_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
        .clock (clock),
        .we    (accept),
        .addr  (col_eff),
        .wdata (bus.iPixel),
        .rdata (mid)
    );

    line_buffer_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb2 (
        .clock (clock),
        .we    (accept),
        .addr  (col_eff),
        .wdata (mid),
        .rdata (top)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col     <= '0;
            row     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            for (int n = 0; n < 9; n++) begin
                win_q[n] <= '0;
            end
        end else begin
            col     <= col_nxt;
            row     <= row_nxt;
            valid_q <= win_ok;
            last_q  <= win_last;
            if (accept) begin
                win_q[SLOT_TL] <= win_q[SLOT_TM];
                win_q[SLOT_TM] <= win_q[SLOT_TR];
                win_q[SLOT_TR] <= top;
                win_q[SLOT_ML] <= win_q[SLOT_MM];
                win_q[SLOT_MM] <= win_q[SLOT_MR];
                win_q[SLOT_MR] <= mid;
                win_q[SLOT_BL] <= win_q[SLOT_BM];
                win_q[SLOT_BM] <= win_q[SLOT_BR];
                win_q[SLOT_BR] <= bus.iPixel;
            end
        end
    end

    always_comb begin
        grid = '0;
        for (int n = 0; n < 9; n++) begin
            grid[n*PIX_W +: PIX_W] = win_q[n];
        end
    end

    assign bus.oGrid  = grid;
    assign bus.oValid = valid_q;
    assign bus.oLast  = last_q;

endmodule
